// File: rtl/cam_cfg_tlp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_cfg_tlp_ctrl
// Purpose  : Parses CfgRd0/CfgWr0 TLPs, performs one CAM register access per
//            request and returns the matching Cpl/CplD completion.
// Revision : 1.0 - initial release
// ============================================================================
module cam_cfg_tlp_ctrl #(
    parameter logic [15:0] COMPLETER_ID = 16'h0100,
    parameter int          ACK_TIMEOUT  = 64,
    parameter int          REG_AW       = 10
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [31:0]       cfg_tlp,
    input  logic              TLP_first,
    input  logic              cfg_tlp_valid,
    output logic              cfg_tlp_ready,
    output logic              reg_req,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    input  logic              reg_ack,
    input  logic [31:0]       reg_rdata,
    output logic [31:0]       cmpl_tlp,
    output logic              cmpl_first,
    output logic              cmpl_valid,
    input  logic              cmpl_ready
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_HDR2 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_ACC  = 3'd4;
    localparam logic [2:0] S_CMPL = 3'd5;

    localparam logic [2:0] FMT_NODATA = 3'b000;
    localparam logic [2:0] FMT_DATA   = 3'b010;
    localparam logic [4:0] TYPE_CFG0  = 5'b00100;
    localparam logic [4:0] TYPE_CPL   = 5'b01010;
    localparam logic [2:0] ST_SC      = 3'b000;
    localparam logic [2:0] ST_UR      = 3'b001;
    localparam logic [2:0] ST_CA      = 3'b100;

    logic [2:0]        state_q,  state_d;
    logic [2:0]        fmt_q,    fmt_d;
    logic              bad_q,    bad_d;
    logic [15:0]       reqid_q,  reqid_d;
    logic [7:0]        tag_q,    tag_d;
    logic [REG_AW-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic [2:0]        status_q, status_d;
    logic [1:0]        beat_q,   beat_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;

    logic w_in_ready;
    logic w_dw0_bad;
    logic w_dw1_bad;
    logic w_is_cpld;

    assign w_in_ready = (state_q != S_ACC) && (state_q != S_CMPL);
    assign w_dw0_bad  = (cfg_tlp[4:0] != TYPE_CFG0)
                     || ((cfg_tlp[7:5] != FMT_NODATA) && (cfg_tlp[7:5] != FMT_DATA))
                     || (cfg_tlp[11:9] != 3'd0) || (cfg_tlp[19:18] != 2'd0)
                     || (cfg_tlp[31:22] != 10'd1);
    assign w_dw1_bad  = (cfg_tlp[31:28] != 4'hF) || (cfg_tlp[27:24] != 4'h0);
    // Only a read that actually completed returns data; CA/UR reads go out as Cpl.
    assign w_is_cpld  = (fmt_q == FMT_NODATA) && (status_q == ST_SC);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= S_IDLE;
            fmt_q    <= '0;
            bad_q    <= 1'b0;
            reqid_q  <= '0;
            tag_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            beat_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            fmt_q    <= fmt_d;
            bad_q    <= bad_d;
            reqid_q  <= reqid_d;
            tag_q    <= tag_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            beat_q   <= beat_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fmt_d    = fmt_q;
        bad_d    = bad_q;
        reqid_d  = reqid_q;
        tag_d    = tag_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        beat_d   = beat_q;
        tmo_d    = '0;
        case (state_q)
            S_IDLE, S_HDR1, S_HDR2, S_DATA: begin
                // A TLP_first beat always restarts parsing, discarding any partial TLP.
                if (cfg_tlp_valid) begin
                    if (TLP_first) begin
                        fmt_d   = cfg_tlp[7:5];
                        bad_d   = w_dw0_bad;
                        state_d = S_HDR1;
                    end else if (state_q == S_HDR1) begin
                        reqid_d = cfg_tlp[15:0];
                        tag_d   = cfg_tlp[23:16];
                        bad_d   = bad_q | w_dw1_bad;
                        state_d = S_HDR2;
                    end else if (state_q == S_HDR2) begin
                        addr_d = cfg_tlp[REG_AW+1:2];
                        if (fmt_q == FMT_DATA) begin
                            state_d = S_DATA;
                        end else if (bad_q) begin
                            status_d = ST_UR;
                            state_d  = S_CMPL;
                        end else begin
                            state_d = S_ACC;
                        end
                    end else if (state_q == S_DATA) begin
                        wdata_d = cfg_tlp;
                        if (bad_q) begin
                            status_d = ST_UR;
                            state_d  = S_CMPL;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
            end
            S_ACC: begin
                if (reg_ack) begin
                    rdata_d  = reg_rdata;
                    status_d = ST_SC;
                    state_d  = S_CMPL;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    status_d = ST_CA;
                    state_d  = S_CMPL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CMPL: begin
                if (cmpl_ready) begin
                    if (beat_q == (w_is_cpld ? 2'd3 : 2'd2)) begin
                        beat_d  = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_tlp_ready = w_in_ready;
        reg_req       = (state_q == S_ACC);
        reg_we        = (state_q == S_ACC) && (fmt_q == FMT_DATA);
        reg_addr      = addr_q;
        reg_wdata     = wdata_q;
        cmpl_valid    = (state_q == S_CMPL);
        cmpl_first    = (state_q == S_CMPL) && (beat_q == 2'd0);
        cmpl_tlp      = '0;
        if (state_q == S_CMPL) begin
            case (beat_q)
                2'd0:    cmpl_tlp = {(w_is_cpld ? 10'd1 : 10'd0), 14'd0,
                                     (w_is_cpld ? FMT_DATA : FMT_NODATA), TYPE_CPL};
                2'd1:    cmpl_tlp = {12'd4, status_q, 1'b0, COMPLETER_ID};
                2'd2:    cmpl_tlp = {1'b0, 7'd0, tag_q, reqid_q};
                default: cmpl_tlp = rdata_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cam_cfg_tlp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_cfg_tlp_ctrl
// Purpose  : Self-checking bench for cam_cfg_tlp_ctrl (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_cfg_tlp_ctrl;
    localparam int          TMO  = 16;
    localparam logic [15:0] CID  = 16'h0100;
    localparam logic [2:0]  RD   = 3'b000;
    localparam logic [2:0]  WR   = 3'b010;
    localparam logic [2:0]  SC   = 3'b000;
    localparam logic [2:0]  UR   = 3'b001;
    localparam logic [2:0]  CA   = 3'b100;
    localparam logic [4:0]  CFG0 = 5'b00100;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [31:0] cfg_tlp = '0;
    logic        TLP_first = 1'b0;
    logic        cfg_tlp_valid = 1'b0;
    logic        cfg_tlp_ready;
    logic        reg_req, reg_we;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic [31:0] cmpl_tlp;
    logic        cmpl_first, cmpl_valid;
    logic        cmpl_ready = 1'b1;

    always #5 pclk = ~pclk;

    cam_cfg_tlp_ctrl #(
        .COMPLETER_ID (CID),
        .ACK_TIMEOUT  (TMO),
        .REG_AW       (10)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .cfg_tlp       (cfg_tlp),
        .TLP_first     (TLP_first),
        .cfg_tlp_valid (cfg_tlp_valid),
        .cfg_tlp_ready (cfg_tlp_ready),
        .reg_req       (reg_req),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_ack       (reg_ack),
        .reg_rdata     (reg_rdata),
        .cmpl_tlp      (cmpl_tlp),
        .cmpl_first    (cmpl_first),
        .cmpl_valid    (cmpl_valid),
        .cmpl_ready    (cmpl_ready)
    );

    typedef struct packed { logic [31:0] d; logic f; } beat_t;
    typedef struct {
        logic [2:0] fmt; logic [4:0] typ; logic [2:0] tc; logic [1:0] attr; logic [9:0] len;
        logic [3:0] fbe; logic [3:0] lbe; logic [15:0] reqid; logic [7:0] tag;
        logic [31:0] dw2; logic [31:0] wdata; int ack; logic [31:0] rdata; int mode;
        int eacc; logic [9:0] eaddr; logic [2:0] est; bit edata; bit lat;
    } vec_t;

    vec_t        tbl [12];
    beat_t       tx_q [$];
    beat_t       sb_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_dly = 0;
    logic [31:0] rd_val = '0;
    int          rdy_mode = 0;
    int          exp_acc = 0;
    logic        exp_we = 1'b0;
    logic [9:0]  exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    bit          chk_lat = 1'b0;
    bit          lat_pend = 1'b0;
    int          ack_cyc = 0;
    int          acc_seen = 0;
    int          req_cnt = 0;
    bit          prev_stall = 1'b0;
    beat_t       prev_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic beat_t mkb(input logic [31:0] d, input logic f);
        beat_t b;
        b.d = d;
        b.f = f;
        return b;
    endfunction

    function automatic logic [31:0] mk_dw0(input logic [2:0] fmt, input logic [4:0] typ,
                                           input logic [2:0] tc, input logic [1:0] attr,
                                           input logic [9:0] len);
        return {len, 2'b00, attr, 6'd0, tc, 1'b0, fmt, typ};
    endfunction

    function automatic logic [31:0] mk_dw1(input logic [3:0] fbe, input logic [3:0] lbe,
                                           input logic [7:0] tag, input logic [15:0] reqid);
        return {fbe, lbe, tag, reqid};
    endfunction

    function automatic vec_t mkv(input logic [2:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                                 input logic [1:0] attr, input logic [9:0] len, input logic [3:0] fbe,
                                 input logic [3:0] lbe, input logic [15:0] reqid, input logic [7:0] tag,
                                 input logic [31:0] dw2, input logic [31:0] wdata, input int ack,
                                 input logic [31:0] rdata, input int mode, input int eacc,
                                 input logic [9:0] eaddr, input logic [2:0] est, input bit edata,
                                 input bit lat);
        vec_t v;
        v.fmt = fmt; v.typ = typ; v.tc = tc; v.attr = attr; v.len = len; v.fbe = fbe; v.lbe = lbe;
        v.reqid = reqid; v.tag = tag; v.dw2 = dw2; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
        v.mode = mode; v.eacc = eacc; v.eaddr = eaddr; v.est = est; v.edata = edata; v.lat = lat;
        return v;
    endfunction

    task automatic push_cmpl(input logic [2:0] st, input bit data, input logic [15:0] reqid,
                             input logic [7:0] tag, input logic [31:0] rdata);
        sb_q.push_back(mkb({(data ? 10'd1 : 10'd0), 14'd0, (data ? WR : RD), 5'b01010}, 1'b1));
        sb_q.push_back(mkb({12'd4, st, 1'b0, CID}, 1'b0));
        sb_q.push_back(mkb({8'h00, tag, reqid}, 1'b0));
        if (data) sb_q.push_back(mkb(rdata, 1'b0));
    endtask

    task automatic load_vec(input vec_t v);
        tx_q.push_back(mkb(mk_dw0(v.fmt, v.typ, v.tc, v.attr, v.len), 1'b1));
        tx_q.push_back(mkb(mk_dw1(v.fbe, v.lbe, v.tag, v.reqid), 1'b0));
        tx_q.push_back(mkb(v.dw2, 1'b0));
        if (v.fmt == WR) tx_q.push_back(mkb(v.wdata, 1'b0));
        ack_dly = v.ack; rd_val = v.rdata; rdy_mode = v.mode; exp_acc = v.eacc;
        exp_we = (v.fmt == WR); exp_addr = v.eaddr; exp_wdata = v.wdata; chk_lat = v.lat;
        push_cmpl(v.est, v.edata, v.reqid, v.tag, v.rdata);
    endtask

    // One clock of driver, register responder and completion sink, all at the falling edge.
    task automatic step();
        @(negedge pclk);
        cyc++;
        if (tx_q.size() != 0) begin
            cfg_tlp = tx_q[0].d; TLP_first = tx_q[0].f; cfg_tlp_valid = 1'b1;
            if (cfg_tlp_ready) void'(tx_q.pop_front());
        end else begin
            cfg_tlp = '0; TLP_first = 1'b0; cfg_tlp_valid = 1'b0;
        end

        reg_ack = 1'b0;
        if (reg_req) begin
            chk("req_addr", reg_addr, exp_addr);
            if (req_cnt == 0) begin
                acc_seen++;
                chk("req_we", reg_we, exp_we);
                chk("req_ready_low", cfg_tlp_ready, 1'b0);
                if (exp_we) chk("req_wdata", reg_wdata, exp_wdata);
            end
            if (ack_dly >= 0 && req_cnt == ack_dly) begin
                reg_ack = 1'b1; reg_rdata = rd_val; ack_cyc = cyc; lat_pend = chk_lat;
            end
            req_cnt++;
        end else if (req_cnt != 0) begin
            if (ack_dly < 0) chk("tmo_cycles", (req_cnt >= TMO && req_cnt <= TMO + 1), 1'b1);
            if (ack_dly == -2) begin
                reg_ack = 1'b1; reg_rdata = 32'hBAD0BAD0;
            end
            req_cnt = 0;
        end

        cmpl_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        if (cmpl_valid) begin
            if (prev_stall) chk("cmpl_hold", cmpl_tlp, prev_b.d);
            if (lat_pend && cmpl_first) begin
                chk("cmpl_latency", cyc - ack_cyc, 1);
                lat_pend = 1'b0;
            end
            if (cmpl_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmpl_extra_beat: actual=%h required=no beat", cmpl_tlp);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("cmpl_data", cmpl_tlp, e.d);
                    chk("cmpl_first", cmpl_first, e.f);
                end
            end
            prev_stall = !cmpl_ready;
            prev_b     = mkb(cmpl_tlp, cmpl_first);
        end else begin
            if (prev_stall) begin
                checks++; errors++;
                $display("FAIL cmpl_valid_drop: actual=0 required=1");
            end
            prev_stall = 1'b0;
        end
    endtask

    task automatic run_txn(input string nm);
        int n = 0;
        acc_seen = 0; req_cnt = 0; lat_pend = 1'b0;
        while ((tx_q.size() != 0 || sb_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk({nm, "_finished"}, (n < 400), 1'b1);
        repeat (4) step();
        chk({nm, "_accesses"}, acc_seen, exp_acc);
        tx_q.delete();
        sb_q.delete();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_cfg_ready"}, cfg_tlp_ready, 1'b1);
        chk({nm, "_reg_req"}, reg_req, 1'b0);
        chk({nm, "_reg_we"}, reg_we, 1'b0);
        chk({nm, "_reg_addr"}, reg_addr, 10'd0);
        chk({nm, "_reg_wdata"}, reg_wdata, 32'd0);
        chk({nm, "_cmpl_valid"}, cmpl_valid, 1'b0);
        chk({nm, "_cmpl_first"}, cmpl_first, 1'b0);
        chk({nm, "_cmpl_tlp"}, cmpl_tlp, 32'd0);
    endtask

    initial begin
        //              fmt typ          tc    attr   len  fbe  lbe  reqid     tag    dw2       wdata         ack rdata          md acc addr    st  dat lat
        tbl[0]  = mkv(RD, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h1234, 8'h5A, 32'h040, 32'h0,        3, 32'hDEADBEEF, 0, 1, 10'h010, SC, 1, 0);
        tbl[1]  = mkv(WR, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'hABCD, 8'h01, 32'h1FC, 32'h12345678, 0, 32'h0,        0, 1, 10'h07F, SC, 0, 1);
        tbl[2]  = mkv(RD, CFG0,        3'd1, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0002, 8'h02, 32'h040, 32'h0,        0, 32'h11111111, 0, 0, 10'h000, UR, 0, 0);
        tbl[3]  = mkv(WR, CFG0,        3'd0, 2'd0, 10'd2, 4'hF, 4'h0, 16'h0003, 8'h03, 32'h044, 32'h55AA55AA, 0, 32'h0,        0, 0, 10'h000, UR, 0, 0);
        tbl[4]  = mkv(RD, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0004, 8'h04, 32'h008, 32'h0,       -1, 32'h0,        0, 1, 10'h002, CA, 0, 0);
        tbl[5]  = mkv(RD, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0005, 8'h05, 32'h00C, 32'h0,        1, 32'hCAFEF00D, 1, 1, 10'h003, SC, 1, 0);
        tbl[6]  = mkv(RD, CFG0,        3'd0, 2'd0, 10'd1, 4'h7, 4'h0, 16'h0006, 8'h06, 32'h040, 32'h0,        0, 32'h0,        0, 0, 10'h000, UR, 0, 0);
        tbl[7]  = mkv(WR, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0007, 8'h07, 32'hFFC, 32'hA5A5A5A5, 2, 32'h0,        1, 1, 10'h3FF, SC, 0, 0);
        tbl[8]  = mkv(RD, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0008, 8'h08, 32'h200, 32'h0,       -2, 32'h0,        0, 1, 10'h080, CA, 0, 0);
        tbl[9]  = mkv(RD, 5'b00101,    3'd0, 2'd0, 10'd1, 4'hF, 4'h0, 16'h0009, 8'h09, 32'h040, 32'h0,        0, 32'h0,        0, 0, 10'h000, UR, 0, 0);
        tbl[10] = mkv(WR, CFG0,        3'd0, 2'd0, 10'd1, 4'hF, 4'hF, 16'h000A, 8'h0A, 32'h040, 32'h77777777, 0, 32'h0,        0, 0, 10'h000, UR, 0, 0);
        tbl[11] = mkv(RD, CFG0,        3'd0, 2'd1, 10'd1, 4'hF, 4'h0, 16'h000B, 8'h0B, 32'h040, 32'h0,        0, 32'h0,        0, 0, 10'h000, UR, 0, 0);

        repeat (3) @(negedge pclk);
        chk_reset("reset");
        preset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            load_vec(tbl[i]);
            run_txn($sformatf("vec%0d", i));
        end

        // Write header cut off at HDR2 by a new read DW0: only the read completes.
        tx_q.push_back(mkb(mk_dw0(WR, CFG0, 3'd0, 2'd0, 10'd1), 1'b1));
        tx_q.push_back(mkb(mk_dw1(4'hF, 4'h0, 8'h66, 16'h9999), 1'b0));
        tx_q.push_back(mkb(mk_dw0(RD, CFG0, 3'd0, 2'd0, 10'd1), 1'b1));
        tx_q.push_back(mkb(mk_dw1(4'hF, 4'h0, 8'h77, 16'h4321), 1'b0));
        tx_q.push_back(mkb(32'h080, 1'b0));
        ack_dly = 1; rd_val = 32'h13579BDF; rdy_mode = 0; exp_acc = 1;
        exp_we = 1'b0; exp_addr = 10'h020; chk_lat = 1'b0;
        push_cmpl(SC, 1'b1, 16'h4321, 8'h77, 32'h13579BDF);
        run_txn("abort_hdr2");

        // Reset asserted while the register access is pending.
        tx_q.push_back(mkb(mk_dw0(RD, CFG0, 3'd0, 2'd0, 10'd1), 1'b1));
        tx_q.push_back(mkb(mk_dw1(4'hF, 4'h0, 8'h10, 16'h1111), 1'b0));
        tx_q.push_back(mkb(32'h040, 1'b0));
        ack_dly = -1; exp_acc = 1; exp_we = 1'b0; exp_addr = 10'h010; acc_seen = 0; req_cnt = 0;
        begin
            int n = 0;
            while (!reg_req && n < 50) begin
                step();
                n++;
            end
        end
        chk("rst_acc_reached", reg_req, 1'b1);
        repeat (2) step();
        #2 preset = 1'b1;
        #1 chk_reset("rst_in_acc");
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        req_cnt = 0; prev_stall = 1'b0; tx_q.delete(); sb_q.delete();

        load_vec(tbl[1]);
        run_txn("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
